// File: rtl/acc_spi_reader.sv
// acc_spi_reader: mode-0 SPI master for an ADXL362 accelerometer.
// After reset it writes POWER_CTL = measure once, then reads XDATA every
// SAMPLE_CYC clocks and presents the sample as an 11-bit offset-binary x_val
// (1024 = level) with a one-cycle x_valid strobe.
// Optional build macro ACC_AVG_EN: x_val becomes the 4-sample moving average
// of the clamped offset values instead of the single latest sample.
module acc_spi_reader #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int SCLK_FREQ  = 1_000_000,
  parameter int SAMPLE_CYC = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spi_miso,
  output logic        spi_sclk,
  output logic        spi_mosi,
  output logic        spi_cs_n,
  output logic [10:0] x_val,
  output logic        x_valid,
  output logic        busy
);

  localparam int HALF  = CLK_FREQ / (2 * SCLK_FREQ);
  localparam int CNT_W = $clog2(2 * HALF + 1);
  localparam int TMR_W = $clog2(SAMPLE_CYC + 1);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(2 * HALF - 1);
  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(SAMPLE_CYC - 1);

  // Command words, MSB first, left-aligned in the 32-bit shifter.
  localparam logic [31:0] INIT_CMD = 32'h0A2D_0200;  // write POWER_CTL = measure
  localparam logic [31:0] READ_CMD = 32'h0B0E_0000;  // read XDATA_L, XDATA_H

  typedef enum logic [2:0] {
    RESET_WAIT,
    INIT_XFER,
    GAP,
    IDLE,
    READ_XFER,
    LATCH
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;        // wait counter / sclk half-period counter
  logic [5:0]         bit_cnt_q, bit_cnt_d; // completed sclk periods in this transfer
  logic               sclk_q, sclk_d;
  logic               cs_n_q, cs_n_d;
  logic               mosi_q, mosi_d;
  logic [31:0]        tx_sr_q, tx_sr_d;
  logic [15:0]        rx_sr_q, rx_sr_d;    // last two received bytes: {XDATA_L, XDATA_H}
  logic [10:0]        x_val_q, x_val_d;
  logic               x_valid_q, x_valid_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic               run_q, run_d;        // sample timer enabled once INIT has finished
  logic               pending_q, pending_d; // one deferred sample tick
  logic               tick;
  logic [5:0]         nbits;
  logic [11:0]        raw;
  logic [10:0]        sample;

`ifdef ACC_AVG_EN
  logic [2:0][10:0]   hist_q, hist_d;      // three previous offset samples, newest at [0]
  logic [12:0]        sum;
`endif

  // Convert a 12-bit two's-complement reading to offset binary, clamped to 11 bits.
  function automatic logic [10:0] to_offset(input logic [11:0] r);
    logic [10:0] res;
    if (r[11] == r[10]) res = {~r[10], r[9:0]};  // in range: add 1024
    else if (r[11])     res = 11'd0;             // below -1024
    else                res = 11'h7FF;           // above +1023
    return res;
  endfunction

  assign raw    = {rx_sr_q[3:0], rx_sr_q[15:8]};
  assign sample = to_offset(raw);
  assign nbits  = (state_q == READ_XFER) ? 6'd32 : 6'd24;

  // Free-running sample timer, started at the end of the INIT transfer.
  always_comb begin
    tick    = run_q && (timer_q == TMR_LAST);
    timer_d = timer_q;
    if (!run_q)    timer_d = '0;
    else if (tick) timer_d = '0;
    else           timer_d = timer_q + 1'b1;
  end

  // Sequencer and SPI shifter: next-state and outputs.
  // NOTE: every signal assigned here gets a default first so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_cnt_d = bit_cnt_q;
    sclk_d    = sclk_q;
    cs_n_d    = cs_n_q;
    mosi_d    = mosi_q;
    tx_sr_d   = tx_sr_q;
    rx_sr_d   = rx_sr_q;
    x_val_d   = x_val_q;
    x_valid_d = 1'b0;
    run_d     = run_q;
    pending_d = pending_q | tick;
`ifdef ACC_AVG_EN
    hist_d    = hist_q;
    sum       = 13'(sample) + 13'(hist_q[0]) + 13'(hist_q[1]) + 13'(hist_q[2]);
`endif

    case (state_q)
      RESET_WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          state_d   = INIT_XFER;
          cnt_d     = '0;
          bit_cnt_d = '0;
          cs_n_d    = 1'b0;
          tx_sr_d   = INIT_CMD;
          mosi_d    = INIT_CMD[31];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      INIT_XFER, READ_XFER: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (sclk_q) begin
            // Falling edge: advance MOSI while sclk is low.
            sclk_d    = 1'b0;
            bit_cnt_d = bit_cnt_q + 6'd1;
            tx_sr_d   = {tx_sr_q[30:0], 1'b0};
            mosi_d    = tx_sr_q[30];
          end else if (bit_cnt_q == nbits) begin
            // Hold half-period after the last falling edge has elapsed.
            cs_n_d = 1'b1;
            if (state_q == INIT_XFER) begin
              state_d = GAP;
              run_d   = 1'b1;
            end else begin
              state_d = LATCH;
            end
          end else begin
            // Rising edge: sample MISO in the same clock.
            sclk_d  = 1'b1;
            rx_sr_d = {rx_sr_q[14:0], spi_miso};
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      GAP: begin
        if (cnt_q == WAIT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      IDLE: begin
        if (tick || pending_q) begin
          // Consume one tick; a tick arriving in this same cycle stays held.
          pending_d = pending_q & tick;
          state_d   = READ_XFER;
          cnt_d     = '0;
          bit_cnt_d = '0;
          cs_n_d    = 1'b0;
          tx_sr_d   = READ_CMD;
          mosi_d    = READ_CMD[31];
        end
      end

      LATCH: begin
        x_valid_d = 1'b1;
`ifdef ACC_AVG_EN
        x_val_d   = sum[12:2];
        hist_d    = {hist_q[1], hist_q[0], sample};
`else
        x_val_d   = sample;
`endif
        state_d   = GAP;
        cnt_d     = '0;
      end

      default: state_d = RESET_WAIT;
    endcase
  end

  // State registers; reset takes effect immediately and aborts any transfer.
  // NOTE: state updates use non-blocking assignments so all flops see pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= RESET_WAIT;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      sclk_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      mosi_q    <= 1'b0;
      tx_sr_q   <= '0;
      rx_sr_q   <= '0;
      x_val_q   <= 11'd1024;
      x_valid_q <= 1'b0;
      timer_q   <= '0;
      run_q     <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      sclk_q    <= sclk_d;
      cs_n_q    <= cs_n_d;
      mosi_q    <= mosi_d;
      tx_sr_q   <= tx_sr_d;
      rx_sr_q   <= rx_sr_d;
      x_val_q   <= x_val_d;
      x_valid_q <= x_valid_d;
      timer_q   <= timer_d;
      run_q     <= run_d;
      pending_q <= pending_d;
    end
  end

`ifdef ACC_AVG_EN
  // Averaging history, preloaded to level so the first outputs ramp from 1024.
  // NOTE: the history is small and must start at a defined value, so it is reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) hist_q <= {3{11'd1024}};
    else      hist_q <= hist_d;
  end
`endif

  assign spi_sclk = sclk_q;
  assign spi_mosi = mosi_q;
  assign spi_cs_n = cs_n_q;
  assign busy     = ~cs_n_q;
  assign x_val    = x_val_q;
  assign x_valid  = x_valid_q;

endmodule

// File: tb/tb_acc_spi_reader.sv
// Testbench for acc_spi_reader: SPI slave model, scoreboard for x_val updates,
// framing/timing checks, mid-transfer reset, and a second instance with a
// short sample period to exercise deferred read starts.
module tb_acc_spi_reader;

  localparam int CLK_FREQ   = 100;
  localparam int SCLK_FREQ  = 10;
  localparam int HALF       = 5;
  localparam int SAMPLE_A   = 400;
  localparam int SAMPLE_B   = 200;

  logic        clk = 1'b0;
  logic        rst;
  logic        spi_miso;
  logic        spi_sclk, spi_mosi, spi_cs_n, x_valid, busy;
  logic [10:0] x_val;
  logic        b_sclk, b_mosi, b_cs_n, b_valid, b_busy;
  logic [10:0] b_val;

  always #5 clk = ~clk;

  acc_spi_reader #(.CLK_FREQ(CLK_FREQ), .SCLK_FREQ(SCLK_FREQ), .SAMPLE_CYC(SAMPLE_A)) dut (
    .clk(clk), .rst(rst), .spi_miso(spi_miso), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
    .spi_cs_n(spi_cs_n), .x_val(x_val), .x_valid(x_valid), .busy(busy));

  acc_spi_reader #(.CLK_FREQ(CLK_FREQ), .SCLK_FREQ(SCLK_FREQ), .SAMPLE_CYC(SAMPLE_B)) dut_b (
    .clk(clk), .rst(rst), .spi_miso(1'b0), .spi_sclk(b_sclk), .spi_mosi(b_mosi),
    .spi_cs_n(b_cs_n), .x_val(b_val), .x_valid(b_valid), .busy(b_busy));

  typedef struct {
    int          rises;
    logic [31:0] mosi;
    int          minh;
    int          maxh;
    int          fall_t;
    int          rise_t;
  } txn_t;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          live_rises = 0;
  int          busy_err = 0;
  txn_t        txn_q[$];
  logic [10:0] exp_q[$];
  logic [15:0] resp_q[$];   // {XDATA_L, XDATA_H}
  int          b_fall_q[$];
  int          b_rise_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // SPI slave model for the main instance: measures framing, captures MOSI,
  // returns XDATA from resp_q once a read command byte has been seen.
  initial begin : slave_a
    logic        cs_p, sclk_p;
    int          hcnt;
    logic [31:0] word;
    txn_t        t;
    cs_p = 1'b1; sclk_p = 1'b0; hcnt = 0; word = '0; spi_miso = 1'b0;
    t = '{rises:0, mosi:32'h0, minh:1000, maxh:0, fall_t:0, rise_t:0};
    forever begin
      @(negedge clk);
      if (!rst) begin
        cs_p = 1'b1; sclk_p = 1'b0; spi_miso = 1'b0; live_rises = 0;
      end else begin
        if (cs_p && !spi_cs_n) begin
          t = '{rises:0, mosi:32'h0, minh:1000, maxh:0, fall_t:cyc, rise_t:0};
          word = '0; hcnt = 0; live_rises = 0;
        end else if (!cs_p) begin
          hcnt++;
          if ((spi_sclk != sclk_p) || spi_cs_n) begin
            if (hcnt < t.minh) t.minh = hcnt;
            if (hcnt > t.maxh) t.maxh = hcnt;
            hcnt = 0;
          end
          if (spi_sclk && !sclk_p) begin
            t.rises++;
            live_rises = t.rises;
            t.mosi = {t.mosi[30:0], spi_mosi};
            if (t.rises == 8 && t.mosi[7:0] == 8'h0B && resp_q.size() > 0)
              word = {16'h0000, resp_q.pop_front()};
          end
          if (spi_cs_n) begin
            t.rise_t = cyc;
            txn_q.push_back(t);
          end
        end
        if (!spi_cs_n && !spi_sclk && t.rises < 32) spi_miso = word[31 - t.rises];
        cs_p = spi_cs_n;
        sclk_p = spi_sclk;
      end
    end
  end

  // Scoreboard monitor: every x_valid pops one expected value.
  initial begin : monitor
    logic        cs_p, v_p;
    int          last_rise;
    logic [10:0] e;
    cs_p = 1'b1; v_p = 1'b0; last_rise = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (!cs_p && spi_cs_n) last_rise = cyc;
        if (x_valid) begin
          check("x_valid_width", {31'b0, v_p}, 32'd0);
          check("x_valid_after_cs_rise", cyc - last_rise, 32'd1);
          if (exp_q.size() == 0) begin
            check("x_valid_unexpected", {31'b0, x_valid}, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("x_val", {21'b0, x_val}, {21'b0, e});
          end
        end
      end
      cs_p = spi_cs_n;
      v_p  = x_valid;
    end
  end

  // busy must mirror chip select; second instance records its cs edges.
  initial begin : side_mon
    logic bcs_p;
    bcs_p = 1'b1;
    forever begin
      @(negedge clk);
      if (busy !== ~spi_cs_n) busy_err++;
      if (b_busy !== ~b_cs_n) busy_err++;
      if (rst) begin
        if (bcs_p && !b_cs_n) b_fall_q.push_back(cyc);
        if (!bcs_p && b_cs_n) b_rise_q.push_back(cyc);
      end
      bcs_p = b_cs_n;
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic wait_txn(output txn_t t, output logic ok, input int budget);
    ok = 1'b0;
    t = '{rises:0, mosi:32'h0, minh:0, maxh:0, fall_t:0, rise_t:0};
    for (int i = 0; i < budget && !ok; i++) begin
      @(posedge clk);
      if (txn_q.size() > 0) begin
        t = txn_q.pop_front();
        ok = 1'b1;
      end
    end
  endtask

  task automatic check_init(input string tag, input int budget, output int rise_t);
    txn_t t;
    logic ok;
    wait_txn(t, ok, budget);
    check({tag, "_seen"}, {31'b0, ok}, 32'd1);
    check({tag, "_rises"}, t.rises, 32'd24);
    check({tag, "_mosi"}, t.mosi, 32'h000A2D02);
    check({tag, "_half_min"}, t.minh, HALF);
    check({tag, "_half_max"}, t.maxh, HALF);
    rise_t = t.rise_t;
  endtask

  // Read vectors: {XDATA_L, XDATA_H} and hand-computed offset value.
  logic [15:0] vec_resp[5] = '{16'h0000, 16'hFBFF, 16'hDC05, 16'h00F8, 16'hFF03};
  logic [10:0] vec_off[5]  = '{11'd1024, 11'd1019, 11'd2047, 11'd0, 11'd2047};

  initial begin : main
    txn_t        t;
    logic        ok;
    int          init_rise, prev_fall, prev_rise, sum;
    logic [10:0] h0, h1, h2;

    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cs_n", {31'b0, spi_cs_n}, 32'd1);
    check("rst_sclk", {31'b0, spi_sclk}, 32'd0);
    check("rst_mosi", {31'b0, spi_mosi}, 32'd0);
    check("rst_x_val", {21'b0, x_val}, 32'd1024);
    check("rst_x_valid", {31'b0, x_valid}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);

    h0 = 11'd1024; h1 = 11'd1024; h2 = 11'd1024;
    for (int k = 0; k < 5; k++) begin
      resp_q.push_back(vec_resp[k]);
`ifdef ACC_AVG_EN
      sum = int'(vec_off[k]) + int'(h0) + int'(h1) + int'(h2);
      exp_q.push_back(11'(sum / 4));
      h2 = h1; h1 = h0; h0 = vec_off[k];
`else
      exp_q.push_back(vec_off[k]);
`endif
    end

    @(negedge clk);
    rst = 1'b1;

    check_init("init", 2000, init_rise);
    prev_fall = 0;
    prev_rise = init_rise;
    for (int k = 0; k < 5; k++) begin
      wait_txn(t, ok, 1000);
      check("read_seen", {31'b0, ok}, 32'd1);
      check("read_rises", t.rises, 32'd32);
      check("read_mosi", t.mosi, 32'h0B0E0000);
      check("read_half_min", t.minh, HALF);
      check("read_half_max", t.maxh, HALF);
      check("cs_high_gap_ok", {31'b0, (t.fall_t - prev_rise) >= 2 * HALF}, 32'd1);
      if (k == 0) check("first_read_delay", t.fall_t - init_rise, SAMPLE_A);
      else        check("read_spacing", t.fall_t - prev_fall, SAMPLE_A);
      prev_fall = t.fall_t;
      prev_rise = t.rise_t;
    end
    repeat (5) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);

    // Deferred start on the short-period instance: its first read must come
    // SAMPLE_B after INIT, the next tick lands mid-read and the follow-up read
    // starts right after the gap instead of waiting for a later tick.
    check("b_events", {31'b0, (b_fall_q.size() >= 3) && (b_rise_q.size() >= 2)}, 32'd1);
    if (b_fall_q.size() >= 3 && b_rise_q.size() >= 2) begin
      check("b_first_read_delay", b_fall_q[1] - b_rise_q[0], SAMPLE_B);
      check("b_deferred_gap_min", {31'b0, (b_fall_q[2] - b_rise_q[1]) >= 2 * HALF}, 32'd1);
      check("b_deferred_gap_max", {31'b0, (b_fall_q[2] - b_rise_q[1]) <= 2 * HALF + 3}, 32'd1);
    end

    // Reset in the middle of byte 3 of the next read.
    ok = 1'b0;
    for (int i = 0; i < 1000 && !ok; i++) begin
      @(negedge clk);
      if (!spi_cs_n && live_rises == 20) ok = 1'b1;
    end
    check("reached_byte3", {31'b0, ok}, 32'd1);
    rst = 1'b0;
    #1;
    check("abort_cs_n", {31'b0, spi_cs_n}, 32'd1);
    check("abort_sclk", {31'b0, spi_sclk}, 32'd0);
    check("abort_x_val", {21'b0, x_val}, 32'd1024);
    check("abort_x_valid", {31'b0, x_valid}, 32'd0);
    check("abort_busy", {31'b0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    txn_q.delete();
    rst = 1'b1;

    check_init("reinit", 2000, init_rise);
    repeat (20) @(negedge clk);
    check("x_val_hold_after_reset", {21'b0, x_val}, 32'd1024);
    check("busy_tracks_cs", busy_err, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
